// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port framebuffer RAM between video scan-out (absolute priority) and a CPU port.
// Latency: video pixel valid 2 cycles after vid_req; CPU write ack 1 cycle and CPU read ack 2 cycles after issue.
// Backpressure: video never stalls; the CPU holds cpu_req while video owns the port, and cpu_wait_cnt counts the stall.
// Build option: define FB_ARB_POSTED_WRITE_EN to add a one-entry posted write buffer for CPU writes.
module fb_arbiter #(
    parameter int FB_WORDS = 64000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic [23:0] vid_data,
    output logic        vid_valid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [23:0] cpu_wdata,
    output logic [23:0] cpu_rdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_wait_cnt,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [23:0] mem_wdata,
    input  logic [23:0] mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_DONE = 2'd2;
    localparam logic [1:0] WR_DONE = 2'd3;

    // One bit wider than the address so FB_WORDS up to 65536 compares correctly.
    localparam logic [16:0] FB_LIMIT = 17'(FB_WORDS);

    logic [1:0]  state_q, state_d;
    logic        vid_p1_q, vid_p1_d;
    logic        vid_valid_q, vid_valid_d;
    logic [23:0] vid_data_q, vid_data_d;
    logic [23:0] cpu_rdata_q, cpu_rdata_d;
    logic        rd_oor_q, rd_oor_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic idle;
    logic done;
    logic cpu_in_range;
    logic cpu_issue;
    logic cpu_mem_go;

    assign idle         = (state_q == IDLE);
    assign done         = (state_q == RD_DONE) || (state_q == WR_DONE);
    assign cpu_in_range = ({1'b0, cpu_addr} < FB_LIMIT);

`ifdef FB_ARB_POSTED_WRITE_EN
    logic        wbuf_vld_q, wbuf_vld_d;
    logic [15:0] wbuf_addr_q, wbuf_addr_d;
    logic [23:0] wbuf_dat_q, wbuf_dat_d;
    logic        drain;

    // The buffered write owns the first video-free IDLE cycle, ahead of any new CPU access.
    assign drain = idle && wbuf_vld_q && !vid_req;

    // With the buffer empty a write is captured even under video traffic; reads still need a free port.
    // Any access behind a full buffer waits so that it cannot overtake the buffered write.
    assign cpu_issue  = idle && cpu_req && !wbuf_vld_q && (cpu_we || !vid_req);

    // Only reads touch the RAM at issue time; writes go through the buffer.
    assign cpu_mem_go = cpu_issue && !cpu_we && cpu_in_range;

    // Memory port mux: video, then buffer drain, then a CPU read.
    always_comb begin
        mem_addr  = 16'd0;
        mem_we    = 1'b0;
        mem_wdata = 24'd0;
        if (!reset) begin
            if (vid_req) begin
                mem_addr = vid_addr;
            end else if (drain) begin
                mem_addr  = wbuf_addr_q;
                mem_we    = 1'b1;
                mem_wdata = wbuf_dat_q;
            end else if (cpu_mem_go) begin
                mem_addr = cpu_addr;
            end
        end
    end

    // Buffer fills on an in-range write capture and empties on drain; out-of-range writes are acked but dropped.
    always_comb begin
        wbuf_vld_d  = wbuf_vld_q;
        wbuf_addr_d = wbuf_addr_q;
        wbuf_dat_d  = wbuf_dat_q;
        if (drain) begin
            wbuf_vld_d = 1'b0;
        end else if (cpu_issue && cpu_we && cpu_in_range) begin
            wbuf_vld_d  = 1'b1;
            wbuf_addr_d = cpu_addr;
            wbuf_dat_d  = cpu_wdata;
        end
    end

    // Buffer registers; reset discards any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbuf_vld_q  <= 1'b0;
            wbuf_addr_q <= 16'd0;
            wbuf_dat_q  <= 24'd0;
        end else begin
            wbuf_vld_q  <= wbuf_vld_d;
            wbuf_addr_q <= wbuf_addr_d;
            wbuf_dat_q  <= wbuf_dat_d;
        end
    end
`else
    // The CPU gets the port only in IDLE and only when video is not using it.
    assign cpu_issue  = idle && cpu_req && !vid_req;

    // Out-of-range accesses complete through the FSM but never reach the RAM.
    assign cpu_mem_go = cpu_issue && cpu_in_range;

    // Memory port mux: video first, then the CPU; an idle port drives all zeros.
    always_comb begin
        mem_addr  = 16'd0;
        mem_we    = 1'b0;
        mem_wdata = 24'd0;
        if (!reset) begin
            if (vid_req) begin
                mem_addr = vid_addr;
            end else if (cpu_mem_go) begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_we ? cpu_wdata : 24'd0;
            end
        end
    end
`endif

    // CPU FSM, read-data capture and wait counter.
    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        rd_oor_d    = rd_oor_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (cpu_issue) begin
                    state_d  = cpu_we ? WR_DONE : RD_WAIT;
                    rd_oor_d = !cpu_in_range;
                end
            end
            RD_WAIT: begin
                // RAM output belongs to the CPU read this cycle; later video reads cannot touch cpu_rdata.
                cpu_rdata_d = rd_oor_q ? 24'd0 : mem_rdata;
                state_d     = RD_DONE;
            end
            RD_DONE: state_d = IDLE;
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (done) begin
            wait_cnt_d = 8'd0;
        end else if (idle && cpu_req && !cpu_issue && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Video read pipeline: address in t, RAM data in t+1, registered pixel visible in t+2.
    always_comb begin
        vid_p1_d    = vid_req;
        vid_valid_d = vid_p1_q;
        vid_data_d  = vid_p1_q ? mem_rdata : vid_data_q;
    end

    // State registers with synchronous reset; reset abandons any CPU transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vid_p1_q    <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= 24'd0;
            cpu_rdata_q <= 24'd0;
            rd_oor_q    <= 1'b0;
            wait_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            vid_p1_q    <= vid_p1_d;
            vid_valid_q <= vid_valid_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
            rd_oor_q    <= rd_oor_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign vid_data     = vid_data_q;
    assign vid_valid    = vid_valid_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_ack      = done && !reset;
    assign cpu_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed bench for fb_arbiter with a behavioural 1-cycle-latency RAM.
// Latency: checks video 2-cycle pipeline and CPU ack timing against hand-computed values.
// Backpressure: exercises video-over-CPU arbitration, wait counting and saturation.
module tb_fb_arbiter;

`ifdef FB_ARB_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic [23:0] vid_data;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [23:0] cpu_wdata;
    logic [23:0] cpu_rdata;
    logic        cpu_ack;
    logic [7:0]  cpu_wait_cnt;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    fb_arbiter #(.FB_WORDS(64000)) dut (
        .clk          (clk),
        .reset        (reset),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_data     (vid_data),
        .vid_valid    (vid_valid),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ack      (cpu_ack),
        .cpu_wait_cnt (cpu_wait_cnt),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten words read back as a fixed address-derived pattern.
    function automatic logic [23:0] pattern(input logic [15:0] a);
        return {a[7:0] ^ 8'hA5, a[15:8] + 8'h11, ~a[7:0]};
    endfunction

    logic [23:0] ram     [0:65535];
    logic        wr_flag [0:65535];

    // Single-port synchronous RAM, read-first, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            wr_flag[mem_addr] <= 1'b1;
        end
        mem_rdata <= (wr_flag[mem_addr] === 1'b1) ? ram[mem_addr] : pattern(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One CPU transaction with vid_req=0; reports issue-cycle port values, ack latency and read data.
    task automatic cpu_xact(input logic we, input logic [15:0] addr, input logic [23:0] wd,
                            output int lat, output logic [23:0] rd, output logic we0,
                            output logic [15:0] addr0, output logic [23:0] wd0);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        #1;
        we0 = mem_we; addr0 = mem_addr; wd0 = mem_wdata;
        lat = 0;
        while (!cpu_ack && lat < 30) begin
            @(posedge clk); #2;
            lat++;
        end
        rd = cpu_rdata;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 24'd0;
        #1;
        chk("ack_single_pulse", 32'(cpu_ack), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [23:0] wdata;
        logic [23:0] exp_rdata;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [23:0] rd;
        logic        we0;
        logic [15:0] addr0;
        logic [23:0] wd0;
        logic        inr;

        vec[0] = '{1'b1, 16'd100,   24'hFF0000, 24'h000000};
        vec[1] = '{1'b0, 16'd100,   24'h000000, 24'hFF0000};
        vec[2] = '{1'b1, 16'd64000, 24'h00ABCD, 24'h000000};
        vec[3] = '{1'b0, 16'd65535, 24'h000000, 24'h000000};
        vec[4] = '{1'b0, 16'd64000, 24'h000000, 24'h000000};
        vec[5] = '{1'b1, 16'd63999, 24'h123456, 24'h000000};
        vec[6] = '{1'b0, 16'd63999, 24'h000000, 24'h123456};
        vec[7] = '{1'b0, 16'd5,     24'h000000, 24'hA011FA};
        vec[8] = '{1'b1, 16'd0,     24'h777777, 24'h000000};
        vec[9] = '{1'b0, 16'd0,     24'h000000, 24'h777777};

        reset = 1'b1; vid_req = 1'b0; vid_addr = 16'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 24'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_vid_valid", 32'(vid_valid), 32'd0);
        chk("rst_vid_data", 32'(vid_data), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_wait_cnt", 32'(cpu_wait_cnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);

        // 320 back-to-back video reads, one pixel per cycle, two cycles behind the request.
        for (int k = 0; k < 323; k++) begin
            @(posedge clk); #1;
            vid_req  = (k < 320);
            vid_addr = (k < 320) ? 16'(k) : 16'd0;
            #1;
            if (k < 320 && (k % 64) == 5) begin
                chk($sformatf("vid_mem_addr[%0d]", k), 32'(mem_addr), 32'(k));
                chk($sformatf("vid_mem_we[%0d]", k), 32'(mem_we), 32'd0);
            end
            chk($sformatf("vid_valid[%0d]", k), 32'(vid_valid), 32'(k >= 2 && k < 322));
            if (k >= 2 && k < 322)
                chk($sformatf("vid_data[%0d]", k), 32'(vid_data), 32'(pattern(16'(k - 2))));
        end
        vid_req = 1'b0; vid_addr = 16'd0;

        // CPU transaction table: ack latency, issue-cycle port values, read data, counter cleared.
        for (int i = 0; i < NV; i++) begin
            cpu_xact(vec[i].we, vec[i].addr, vec[i].wdata, lat, rd, we0, addr0, wd0);
            inr = (vec[i].addr < 16'd64000);
            chk($sformatf("tbl_lat[%0d]", i), 32'(lat), vec[i].we ? 32'd1 : 32'd2);
            chk($sformatf("tbl_mem_we[%0d]", i), 32'(we0), 32'(vec[i].we && inr && !POSTED));
            chk($sformatf("tbl_mem_addr[%0d]", i), 32'(addr0),
                (inr && !(POSTED && vec[i].we)) ? 32'(vec[i].addr) : 32'd0);
            chk($sformatf("tbl_mem_wdata[%0d]", i), 32'(wd0),
                (vec[i].we && inr && !POSTED) ? 32'(vec[i].wdata) : 32'd0);
            if (!vec[i].we)
                chk($sformatf("tbl_rdata[%0d]", i), 32'(rd), 32'(vec[i].exp_rdata));
            chk($sformatf("tbl_wait_cnt[%0d]", i), 32'(cpu_wait_cnt), 32'd0);
        end

        // CPU read blocked by 10 cycles of video, then issued on the first free cycle.
        @(posedge clk); #1;
        vid_req = 1'b1; vid_addr = 16'd7;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd100;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("arb_vid_addr[%0d]", k), 32'(mem_addr), 32'd7);
            chk($sformatf("arb_no_ack[%0d]", k), 32'(cpu_ack), 32'd0);
            @(posedge clk); #1;
        end
        vid_req = 1'b0; vid_addr = 16'd0;
        #1;
        chk("arb_wait_cnt_10", 32'(cpu_wait_cnt), 32'd10);
        chk("arb_issue_addr", 32'(mem_addr), 32'd100);
        chk("arb_issue_we", 32'(mem_we), 32'd0);
        lat = 0;
        while (!cpu_ack && lat < 30) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("arb_lat", 32'(lat), 32'd2);
        chk("arb_rdata", 32'(cpu_rdata), 32'hFF0000);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        #1;
        chk("arb_wait_cnt_clr", 32'(cpu_wait_cnt), 32'd0);

        // Wait counter saturates at 255 under 300 cycles of video.
        @(posedge clk); #1;
        vid_req = 1'b1; vid_addr = 16'd7;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd5;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (k == 254) chk("sat_wait_cnt_254", 32'(cpu_wait_cnt), 32'd254);
            @(posedge clk); #1;
        end
        #1;
        chk("sat_wait_cnt_255", 32'(cpu_wait_cnt), 32'd255);
        vid_req = 1'b0;
        lat = 0;
        while (!cpu_ack && lat < 30) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("sat_lat", 32'(lat), 32'd2);
        chk("sat_rdata", 32'(cpu_rdata), 32'hA011FA);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        #1;
        chk("sat_wait_cnt_clr", 32'(cpu_wait_cnt), 32'd0);

        // Reset in RD_WAIT abandons the read with no ack and clears all outputs.
        @(posedge clk); #1;
        vid_req = 1'b1; vid_addr = 16'd7;
        @(posedge clk); #1;
        vid_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd100;
        @(posedge clk); #1;
        reset = 1'b1; cpu_req = 1'b0;
        #1;
        chk("rdw_no_ack", 32'(cpu_ack), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rdw_ack", 32'(cpu_ack), 32'd0);
        chk("rdw_vid_valid", 32'(vid_valid), 32'd0);
        chk("rdw_vid_data", 32'(vid_data), 32'd0);
        chk("rdw_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rdw_wait_cnt", 32'(cpu_wait_cnt), 32'd0);
        chk("rdw_mem_we", 32'(mem_we), 32'd0);
        chk("rdw_mem_addr", 32'(mem_addr), 32'd0);
        // Same cycle: a write is accepted immediately, proving the FSM is back in IDLE.
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd200; cpu_wdata = 24'h00BEEF;
        #1;
        chk("post_rst_mem_we", 32'(mem_we), 32'(!POSTED));
        @(posedge clk); #2;
        chk("post_rst_ack", 32'(cpu_ack), 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_xact(1'b0, 16'd200, 24'd0, lat, rd, we0, addr0, wd0);
        chk("post_rst_rd_lat", 32'(lat), 32'd2);
        chk("post_rst_rdata", 32'(rd), 32'h00BEEF);

`ifdef FB_ARB_POSTED_WRITE_EN
        // Posted write under continuous video, then a read that must wait for the drain.
        @(posedge clk); #1;
        vid_req = 1'b1; vid_addr = 16'd0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd300; cpu_wdata = 24'h0A0B0C;
        #1;
        chk("pw_capture_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk); #2;
        chk("pw_ack", 32'(cpu_ack), 32'd1);
        @(posedge clk); #1;
        cpu_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("pw_hold_we[%0d]", k), 32'(mem_we), 32'd0);
            chk($sformatf("pw_hold_ack[%0d]", k), 32'(cpu_ack), 32'd0);
            @(posedge clk); #1;
        end
        vid_req = 1'b0;
        #1;
        chk("pw_drain_we", 32'(mem_we), 32'd1);
        chk("pw_drain_addr", 32'(mem_addr), 32'd300);
        chk("pw_drain_wdata", 32'(mem_wdata), 32'h0A0B0C);
        @(posedge clk); #2;
        chk("pw_rd_issue_addr", 32'(mem_addr), 32'd300);
        chk("pw_rd_issue_we", 32'(mem_we), 32'd0);
        @(posedge clk); #2;
        chk("pw_rd_wait_ack", 32'(cpu_ack), 32'd0);
        @(posedge clk); #2;
        chk("pw_rd_ack", 32'(cpu_ack), 32'd1);
        chk("pw_rd_data", 32'(cpu_rdata), 32'h0A0B0C);
        @(posedge clk); #1;
        cpu_req = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
